tap_decoder: RTL and testbench
==============================

Name: tap_decoder

Overview:
- Receive side of the JTAG USER data register.
- While the USER instruction is loaded, it deserializes TDI bits shifted in during Shift-DR, LSB first.
- On Update-DR it presents the word as a parallel word with a one-cycle valid pulse.
- Sits beside tap_encoder on the same BSCAN TAP signals. Frames whose bit count differs from DATA_WIDTH are rejected and flagged.

Parameters:
- DATA_WIDTH, 32, width of the parallel word and of a legal DR frame in bits (>= 2).

Ports:
- tck  input  1  TAP clock; all logic on its rising edge.
- test_logic_reset  input  1  asynchronous, active-high reset.
- tdi  input  1  serial data from the TAP.
- ir_is_user  input  1  USER instruction currently selected.
- capture_dr  input  1  TAP in Capture-DR.
- shift_dr  input  1  TAP in Shift-DR.
- update_dr  input  1  TAP in Update-DR.
- data  output  DATA_WIDTH  last accepted word.
- valid  output  1  one-tck pulse: data just updated.
- length_error  output  1  one-tck pulse: frame rejected for wrong bit count.

Behaviour:
- Reset (asynchronous assert): clears everything.
  - Outputs: data = 0, valid = 0, length_error = 0.
  - Internals: shift_reg = 0, bit_cnt = 0, state = IDLE.
- Reset release is synchronous to tck. Reset mid-frame discards the frame; no valid or error is emitted.
- State machine: IDLE, SHIFT.
  - IDLE -> SHIFT when ir_is_user & capture_dr. On the same edge, bit_cnt <= 0; shift_reg is not cleared.
  - SHIFT, ir_is_user & shift_dr: shift_reg <= {tdi, shift_reg[DATA_WIDTH-1:1]}. The first bit shifted ends at bit 0 after DATA_WIDTH shifts. bit_cnt increments and saturates at DATA_WIDTH+1.
  - SHIFT, ir_is_user & update_dr: state -> IDLE.
    - If bit_cnt == DATA_WIDTH: data <= shift_reg and valid = 1 for the next cycle.
    - Otherwise data is held and length_error = 1 for the next cycle.
  - SHIFT, ir_is_user deasserted: state -> IDLE. Frame discarded silently, no pulse.
  - SHIFT, capture_dr again (Capture without Update, e.g. via Exit2/Pause loops): restart. bit_cnt <= 0, stay in SHIFT.
- Signals ignored in IDLE:
  - update_dr does nothing; no valid and no error.
  - shift_dr shifts nothing; bit_cnt is not touched.
- Priority when strobes overlap (illegal in a real TAP, defined anyway): capture_dr > update_dr > shift_dr.
- bit_cnt width: $clog2(DATA_WIDTH+2). Saturation guarantees an overrun never wraps back to a legal count.
- Overrun (bit_cnt > DATA_WIDTH): shift_reg holds the last DATA_WIDTH bits, but the frame is still rejected with length_error.
- Latency:
  - valid asserts the cycle after the tck edge that sampled update_dr.
  - data changes on that same edge and stays stable until the next accepted frame.
- valid and length_error are registered, never asserted together, and last exactly one tck each.
- There is no tdo output. The read path belongs to tap_encoder.

Test Plan (DATA_WIDTH=8):
- Reset, then USER IR: capture, shift tdi LSB-first 1,0,1,0,0,1,0,1, then update -> data = 0xA5, valid high exactly one cycle after the update edge, length_error = 0.
- Legal frame of 0x3C followed by a 7-bit frame of 0xFF -> first frame gives data = 0x3C with valid. Second frame gives length_error pulse, data stays 0x3C, no valid.
- Shift 12 bits (8 bits of 0x5A, then four 1s) then update -> length_error pulse, data unchanged, bit_cnt saturated at 9.
- ir_is_user = 0 for a full capture/8-shift/update of 0xC3 -> no valid, no length_error, data unchanged. Then ir_is_user drops mid-shift of a USER frame -> no pulse on the next update.
- Assert test_logic_reset asynchronously after 4 of 8 shifts -> data = 0, valid = 0, length_error = 0 immediately without a tck edge. The next complete frame 0x81 -> data = 0x81 with valid.
- Capture, 3 shifts, second capture, 8 shifts of 0x0F, update -> data = 0x0F with valid; the restart is honoured.

Source files
------------

// File: rtl/tap_decoder.sv
// Receive side of the JTAG USER data register: deserialises TDI during Shift-DR
// and presents the word on Update-DR, rejecting frames of the wrong bit count.
module tap_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  tck,
    input  logic                  test_logic_reset,
    input  logic                  tdi,
    input  logic                  ir_is_user,
    input  logic                  capture_dr,
    input  logic                  shift_dr,
    input  logic                  update_dr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  length_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_reg_n;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0]   data_n;
    logic                    valid_n, length_error_n;

    always_ff @(posedge tck or posedge test_logic_reset) begin
        if (test_logic_reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            data         <= '0;
            valid        <= 1'b0;
            length_error <= 1'b0;
        end else begin
            state        <= state_n;
            shift_reg    <= shift_reg_n;
            bit_cnt      <= bit_cnt_n;
            data         <= data_n;
            valid        <= valid_n;
            length_error <= length_error_n;
        end
    end

    // Strobe priority is capture > update > shift; losing ir_is_user overrides all.
    always_comb begin
        state_n        = state;
        shift_reg_n    = shift_reg;
        bit_cnt_n      = bit_cnt;
        data_n         = data;
        valid_n        = 1'b0;
        length_error_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (ir_is_user && capture_dr) begin
                    state_n   = SHIFT;
                    bit_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (!ir_is_user) begin
                    state_n = IDLE;
                end else if (capture_dr) begin
                    bit_cnt_n = '0;
                end else if (update_dr) begin
                    state_n = IDLE;
                    if (bit_cnt == CNT_FULL) begin
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                    end else begin
                        length_error_n = 1'b1;
                    end
                end else if (shift_dr) begin
                    shift_reg_n = {tdi, shift_reg[DATA_WIDTH-1:1]};
                    // Saturate so an overrun can never wrap back to a legal count.
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tap_decoder.sv
// Self-checking bench for tap_decoder (DATA_WIDTH=8): vector table of frames
// plus hand-written sequences, with a pulse scoreboard checked every cycle.
module tb_tap_decoder;

    localparam int DW = 8;

    logic          tck = 1'b0;
    logic          test_logic_reset;
    logic          tdi;
    logic          ir_is_user;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic [DW-1:0] data;
    logic          valid;
    logic          length_error;

    tap_decoder #(.DATA_WIDTH(DW)) dut (
        .tck              (tck),
        .test_logic_reset (test_logic_reset),
        .tdi              (tdi),
        .ir_is_user       (ir_is_user),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .data             (data),
        .valid            (valid),
        .length_error     (length_error)
    );

    always #5 tck = ~tck;

    typedef struct {
        int            nbits;
        logic [15:0]   bits;
        logic          user;
        logic          exp_valid;
        logic          exp_err;
        logic [DW-1:0] exp_data;
        int            exp_cnt;
    } vec_t;

    typedef struct {
        int            due;
        logic          v;
        logic          e;
        logic [DW-1:0] d;
    } exp_t;

    vec_t          tbl[10];
    exp_t          q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(posedge tck) cyc <= cyc + 1;

    // Every cycle: either a scheduled pulse is due, or outputs must be quiet and data held.
    always @(negedge tck) begin
        if (test_logic_reset) exp_data = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            check("pulse_valid", 32'(valid), 32'(e.v));
            check("pulse_err", 32'(length_error), 32'(e.e));
            check("pulse_data", 32'(data), 32'(e.d));
            if (e.v) exp_data = e.d;
        end else begin
            check("idle_valid", 32'(valid), 0);
            check("idle_err", 32'(length_error), 0);
            check("held_data", 32'(data), 32'(exp_data));
        end
    end

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    task automatic idle_strobes();
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        tdi        = 1'b0;
    endtask

    task automatic capture(input logic user);
        idle_strobes();
        ir_is_user = user;
        capture_dr = 1'b1;
        step();
    endtask

    task automatic shift_bits(input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            idle_strobes();
            shift_dr = 1'b1;
            tdi      = bits[i];
            step();
        end
    endtask

    task automatic update(input logic ev, input logic ee, input logic [DW-1:0] ed);
        exp_t e;
        idle_strobes();
        update_dr = 1'b1;
        if (ev || ee) begin
            e.due = cyc + 1;
            e.v   = ev;
            e.e   = ee;
            e.d   = ev ? ed : exp_data;
            q.push_back(e);
        end
        step();
        idle_strobes();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8,  16'h00A5, 1'b1, 1'b1, 1'b0, 8'hA5, 8};
        tbl[1] = '{8,  16'h003C, 1'b1, 1'b1, 1'b0, 8'h3C, 8};
        tbl[2] = '{7,  16'h007F, 1'b1, 1'b0, 1'b1, 8'h00, 7};
        tbl[3] = '{12, 16'h0F5A, 1'b1, 1'b0, 1'b1, 8'h00, 9};
        tbl[4] = '{8,  16'h00C3, 1'b0, 1'b0, 1'b0, 8'h00, -1};
        tbl[5] = '{0,  16'h0000, 1'b1, 1'b0, 1'b1, 8'h00, 0};
        tbl[6] = '{9,  16'h01FF, 1'b1, 1'b0, 1'b1, 8'h00, 9};
        tbl[7] = '{8,  16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 8};
        tbl[8] = '{8,  16'h00FF, 1'b1, 1'b1, 1'b0, 8'hFF, 8};
        tbl[9] = '{8,  16'h0096, 1'b1, 1'b1, 1'b0, 8'h96, 8};

        test_logic_reset = 1'b1;
        ir_is_user = 1'b0;
        idle_strobes();
        repeat (3) step();
        check("reset_data", 32'(data), 0);
        check("reset_valid", 32'(valid), 0);
        check("reset_err", 32'(length_error), 0);
        test_logic_reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            capture(tbl[i].user);
            shift_bits(tbl[i].nbits, tbl[i].bits);
            if (tbl[i].exp_cnt >= 0)
                check("bit_cnt", 32'(dut.bit_cnt), 32'(tbl[i].exp_cnt));
            update(tbl[i].exp_valid, tbl[i].exp_err, tbl[i].exp_data);
        end

        // ir_is_user drops mid-shift: frame dropped silently, later update ignored.
        capture(1'b1);
        shift_bits(3, 16'h0007);
        idle_strobes();
        ir_is_user = 1'b0;
        step();
        ir_is_user = 1'b1;
        shift_bits(5, 16'h001F);
        update(1'b0, 1'b0, '0);

        // Asynchronous reset mid-frame, checked before any tck edge.
        capture(1'b1);
        shift_bits(4, 16'h0081);
        #1;
        test_logic_reset = 1'b1;
        #1;
        check("async_data", 32'(data), 0);
        check("async_valid", 32'(valid), 0);
        check("async_err", 32'(length_error), 0);
        step();
        step();
        test_logic_reset = 1'b0;
        step();
        // Shifts and update in IDLE must be ignored.
        shift_bits(3, 16'h0007);
        check("idle_shift_cnt", 32'(dut.bit_cnt), 0);
        update(1'b0, 1'b0, '0);
        capture(1'b1);
        shift_bits(8, 16'h0081);
        update(1'b1, 1'b0, 8'h81);

        // Capture again (with an overlapping update) restarts the frame.
        capture(1'b1);
        shift_bits(3, 16'h0007);
        idle_strobes();
        capture_dr = 1'b1;
        update_dr  = 1'b1;
        step();
        check("restart_cnt", 32'(dut.bit_cnt), 0);
        shift_bits(8, 16'h000F);
        update(1'b1, 1'b0, 8'h0F);

        repeat (3) step();
        check("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
